// File: rtl/strip_frame_scheduler_pkg.sv
// Shared constants for the LED-strip frame scheduler: frame FSM encoding,
// default geometry/timing and the BRAM read latency.
package strip_frame_scheduler_pkg;

   localparam logic [1:0] FRAME_IDLE      = 2'd0;
   localparam logic [1:0] FRAME_COUNT     = 2'd1;
   localparam logic [1:0] FRAME_WAIT_IDLE = 2'd2;

   localparam int DEFAULT_FRAME_PERIOD = 1000000;
   localparam int DEFAULT_STRIP_BYTES  = 480;
   localparam int READ_LATENCY         = 2;

   // Index width that stays legal for a single requester.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first unmasked requester at or after ptr.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [N-1:0]     mask,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   logic [N-1:0]     cand;
   logic [IDX_W-1:0] pos;

   assign cand = req & ~mask;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      pos   = '0;
      for (int k = 0; k < N; k++) begin
         pos = IDX_W'((32'(ptr) + 32'(k)) % 32'(N));
         if (!found && cand[pos]) begin
            found      = 1'b1;
            idx        = pos;
            grant[pos] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/strip_frame_scheduler.sv
// Frame sequencer and BRAM port-A sharer for NUM_STRIPS WS2812 strip drivers,
// with double-banked frame buffer swapped only at frame boundaries.
module strip_frame_scheduler
   import strip_frame_scheduler_pkg::*;
#(
   parameter int NUM_STRIPS   = 4,
   parameter int ADDR_WIDTH   = 13,
   parameter int STRIP_BYTES  = DEFAULT_STRIP_BYTES,
   parameter int OFFSET_WIDTH = 9,
   parameter int FRAME_PERIOD = DEFAULT_FRAME_PERIOD
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               enable,
   input  logic                               swap_req,
   input  logic [NUM_STRIPS-1:0]              strip_busy,
   input  logic [NUM_STRIPS-1:0]              req,
   input  logic [NUM_STRIPS*OFFSET_WIDTH-1:0] req_offset,
   output logic [NUM_STRIPS-1:0]              gnt,
   output logic [NUM_STRIPS-1:0]              rd_valid,
   output logic [7:0]                         rd_data,
   output logic [ADDR_WIDTH-1:0]              mem_addr,
   input  logic [7:0]                         mem_dout,
   output logic                               frame_start,
   output logic                               display_bank,
   output logic                               swap_done,
   output logic [7:0]                         overrun_count
);

   localparam int IDX_W = idx_width(NUM_STRIPS);
   localparam int LOW_W = ADDR_WIDTH - 1;
   localparam int CNT_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;

   if (NUM_STRIPS * STRIP_BYTES > (1 << LOW_W)) begin : g_chk_addr
      $error("strip_frame_scheduler: strips do not fit in one bank");
   end
   if ((1 << OFFSET_WIDTH) < STRIP_BYTES) begin : g_chk_offset
      $error("strip_frame_scheduler: OFFSET_WIDTH too small for STRIP_BYTES");
   end

   logic [IDX_W-1:0]        rr_ptr;
   logic [NUM_STRIPS-1:0]   win_onehot;
   logic [IDX_W-1:0]        win_idx;
   logic                    win_found;
   logic [OFFSET_WIDTH-1:0] win_offset;
   logic [LOW_W-1:0]        win_low;
   logic                    win_oor;

   logic             pipe_valid [READ_LATENCY];
   logic [IDX_W-1:0] pipe_idx   [READ_LATENCY];
   logic             pipe_oor   [READ_LATENCY];

   logic [1:0]       frame_state;
   logic [1:0]       frame_next;
   logic [CNT_W-1:0] frame_cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [7:0]       overrun_next;
   logic             fire;
   logic             swap_pending;

   // The registered grant masks its own strip, so nobody wins twice in a row.
   rr_arbiter #(
      .N     (NUM_STRIPS),
      .IDX_W (IDX_W)
   ) u_arb (
      .req   (req),
      .mask  (gnt),
      .ptr   (rr_ptr),
      .grant (win_onehot),
      .idx   (win_idx),
      .found (win_found)
   );

   always_comb begin
      win_offset = req_offset[32'(win_idx) * OFFSET_WIDTH +: OFFSET_WIDTH];
      win_low    = LOW_W'(win_idx) * LOW_W'(STRIP_BYTES) + LOW_W'(win_offset);
      win_oor    = 32'(win_offset) >= 32'(STRIP_BYTES);
   end

   // The bank bit is frozen into mem_addr at grant time; later swaps cannot touch it.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt      <= '0;
         rr_ptr   <= '0;
         mem_addr <= '0;
         rd_valid <= '0;
         rd_data  <= '0;
         for (int s = 0; s < READ_LATENCY; s++) begin
            pipe_valid[s] <= 1'b0;
            pipe_idx[s]   <= '0;
            pipe_oor[s]   <= 1'b0;
         end
      end else begin
         gnt <= win_onehot;
         if (win_found) begin
            rr_ptr   <= (win_idx == IDX_W'(NUM_STRIPS - 1)) ? '0 : win_idx + 1'b1;
            mem_addr <= {display_bank, win_low};
         end
         pipe_valid[0] <= win_found;
         pipe_idx[0]   <= win_idx;
         pipe_oor[0]   <= win_oor;
         for (int s = 1; s < READ_LATENCY; s++) begin
            pipe_valid[s] <= pipe_valid[s-1];
            pipe_idx[s]   <= pipe_idx[s-1];
            pipe_oor[s]   <= pipe_oor[s-1];
         end
         rd_valid <= pipe_valid[READ_LATENCY-1] ?
                     NUM_STRIPS'(1) << pipe_idx[READ_LATENCY-1] : '0;
         if (pipe_valid[READ_LATENCY-1]) begin
            rd_data <= pipe_oor[READ_LATENCY-1] ? 8'h00 : mem_dout;
         end
      end
   end

   always_comb begin
      fire         = 1'b0;
      frame_next   = frame_state;
      cnt_next     = frame_cnt;
      overrun_next = overrun_count;
      if (!enable) begin
         frame_next = FRAME_IDLE;
         cnt_next   = '0;
      end else begin
         case (frame_state)
            FRAME_IDLE: begin
               fire       = 1'b1;
               frame_next = FRAME_COUNT;
               cnt_next   = '0;
            end
            FRAME_COUNT: begin
               if (frame_cnt == CNT_W'(FRAME_PERIOD - 1)) begin
                  if (strip_busy == '0) begin
                     fire     = 1'b1;
                     cnt_next = '0;
                  end else begin
                     frame_next = FRAME_WAIT_IDLE;
                     if (overrun_count != 8'hFF) overrun_next = overrun_count + 8'd1;
                  end
               end else begin
                  cnt_next = frame_cnt + 1'b1;
               end
            end
            FRAME_WAIT_IDLE: begin
               if (strip_busy == '0) begin
                  fire       = 1'b1;
                  cnt_next   = '0;
                  frame_next = FRAME_COUNT;
               end
            end
            default: frame_next = FRAME_IDLE;
         endcase
      end
   end

   // A swap request arriving on the frame-start edge itself still lands on that frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_state   <= FRAME_IDLE;
         frame_cnt     <= '0;
         overrun_count <= '0;
         frame_start   <= 1'b0;
         swap_done     <= 1'b0;
         swap_pending  <= 1'b0;
         display_bank  <= 1'b0;
      end else begin
         frame_state   <= frame_next;
         frame_cnt     <= cnt_next;
         overrun_count <= overrun_next;
         frame_start   <= fire;
         swap_done     <= fire & (swap_pending | swap_req);
         if (fire && (swap_pending || swap_req)) begin
            display_bank <= ~display_bank;
            swap_pending <= 1'b0;
         end else if (swap_req) begin
            swap_pending <= 1'b1;
         end
      end
   end

endmodule

// File: doc/strip_frame_scheduler.md
Name: strip_frame_scheduler

Overview:
- Sequences LED-strip refresh frames and shares the single BRAM read port (port A) among NUM_STRIPS strip drivers.
- Frame buffer is double-banked; address MSB selects the bank. The SPI side writes the hidden bank and requests a swap, which is applied only at a frame boundary.
- Sits between blk_mem port A and the per-strip WS2812 pulse generators.

Parameters:
- NUM_STRIPS, 4: number of strip drivers / requesters.
- ADDR_WIDTH, 13: BRAM address width; MSB is the bank select.
- STRIP_BYTES, 480: bytes per strip (160 LEDs x 3 channels).
- OFFSET_WIDTH, 9: per-strip byte offset width; must satisfy 2^OFFSET_WIDTH >= STRIP_BYTES.
- FRAME_PERIOD, 1000000: clk cycles between frame starts (20 ms at 50 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  frame sequencing enable
- swap_req  in  1  one-cycle pulse from the SPI writer: hidden bank complete
- strip_busy  in  NUM_STRIPS  strip i is still shifting out the current frame
- req  in  NUM_STRIPS  strip i requests one byte
- req_offset  in  NUM_STRIPS*OFFSET_WIDTH  byte offset for strip i; slice i is bits [i*OFFSET_WIDTH +: OFFSET_WIDTH]
- gnt  out  NUM_STRIPS  one-hot, one-cycle grant
- rd_valid  out  NUM_STRIPS  one-hot, one-cycle data-valid strobe
- rd_data  out  8  read byte, shared by all strips
- mem_addr  out  ADDR_WIDTH  BRAM port A address (registered)
- mem_dout  in  8  BRAM port A data (1-cycle registered read)
- frame_start  out  1  one-cycle pulse to all strips
- display_bank  out  1  bank currently being displayed; the SPI writer targets the opposite bank
- swap_done  out  1  one-cycle pulse when display_bank toggles
- overrun_count  out  8  saturating count of deferred frame starts

Behaviour:
- Reset: all outputs are 0; the round-robin pointer is 0; frame state is IDLE; swap_pending is 0.
- Arbitration:
  - Round-robin. Candidates are strips with req[i]=1 and gnt[i]=0 in the current cycle, so a strip is granted at most once every 2 cycles.
  - Search starts at the pointer. Winner w gets gnt[w]=1 on the next edge. Pointer becomes (w+1) mod NUM_STRIPS. With no candidates, the pointer holds.
- Address generation:
  - On the same edge as gnt[w], mem_addr = {display_bank, w*STRIP_BYTES + offset_w}.
  - The lower field is ADDR_WIDTH-1 bits wide. Elaboration check: NUM_STRIPS*STRIP_BYTES <= 2^(ADDR_WIDTH-1).
  - If offset_w >= STRIP_BYTES, the grant is still issued but the returned byte is forced to 0x00.
- Read pipeline:
  - A shift register carries {strip index, valid, oor} alongside the read.
  - rd_valid[w] and rd_data are asserted exactly 2 cycles after gnt[w]. Reads are fully pipelined, one per cycle.
  - rd_data holds its value between strobes.
  - The bank bit used for a read is captured at grant time. A swap never alters an in-flight read.
- Frame FSM:
  - IDLE: counter = 0. When enable=1, pulse frame_start on the next edge and go to COUNT.
  - COUNT: the counter increments. When counter == FRAME_PERIOD-1:
    - if strip_busy == 0, pulse frame_start, reset the counter to 0, and stay in COUNT;
    - else increment overrun_count (saturates at 255) and go to WAIT_IDLE.
  - WAIT_IDLE: counter holds. In the first cycle with strip_busy == 0, pulse frame_start, reset the counter to 0, and go to COUNT.
  - enable=0 in any state: go to IDLE on the next edge with no frame_start. Arbitration and in-flight reads continue.
- Bank swap:
  - swap_req sets swap_pending.
  - On any edge that pulses frame_start with (swap_pending | swap_req)=1: toggle display_bank, pulse swap_done in the same cycle as frame_start, and clear swap_pending.
  - Multiple swap_req pulses before a frame start collapse into one swap.
- Simultaneous events: a swap_req in the frame_start cycle is applied at that frame. A grant issued in that cycle uses the old bank.
- Reset mid-operation: pipelines are flushed, no rd_valid is issued for in-flight reads, and the bank returns to 0.

Decomposition:
- Shared package: frame FSM state encoding (IDLE, COUNT, WAIT_IDLE), default FRAME_PERIOD, STRIP_BYTES, and the BRAM read latency constant (2).
- One sub-module: rr_arbiter (req, mask, pointer -> one-hot winner + index), reusable for the port-B SPI/host sharing later.

Test Plan:
- Reset then enable=1, FRAME_PERIOD=100, strip_busy=0 -> frame_start pulses 1 cycle after enable, then every 100 cycles; overrun_count=0.
- All 4 strips hold req=1 with offset=5 each -> grants cycle 0,1,2,3,0,... (never back-to-back to one strip); mem_addr = 5, 485, 965, 1445; rd_valid 2 cycles after each grant with mem_dout data.
- strip_busy[2]=1 held for 30 cycles past the boundary -> overrun_count=1, frame_start in the first cycle after busy drops, next frame 100 cycles later.
- swap_req mid-frame, then again in the frame_start cycle of the following frame -> display_bank toggles at each of those two frame starts with swap_done; mem_addr MSB=1 for grants after the first toggle; a read granted in the swap cycle keeps MSB=0.
- req_offset=480 on strip 1 -> gnt issued, rd_valid[1] after 2 cycles, rd_data=0x00 regardless of mem_dout.
- rst asserted 1 cycle after a grant -> no rd_valid, all outputs 0, display_bank=0, the next grant after release goes to strip 0 first.
